// File: rtl/dcache_sa_pkg.sv
// Shared types and helpers for the set-associative write-back data cache.
package dcache_sa_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB     = 2'd1,
      REFILL = 2'd2
   } state_t;

   // Width of an index able to address n items; never narrower than one bit.
   function automatic int unsigned clog2w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Word 0 sits in the most-significant slice of a line.
   function automatic int unsigned word_lsb(input int unsigned off,
                                            input int unsigned words,
                                            input int unsigned word_w);
      return (words - 1 - off) * word_w;
   endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: SETS entries of {valid, dirty, tag, data} with word and line writes.
module dcache_way
   import dcache_sa_pkg::*;
#(
   parameter int unsigned SETS            = 4,
   parameter int unsigned IDX_W           = 2,
   parameter int unsigned OFF_W           = 2,
   parameter int unsigned TAG_W           = 12,
   parameter int unsigned WORD_W          = 16,
   parameter int unsigned WORDS_PER_BLOCK = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [IDX_W-1:0]                  idx,
   output logic                              rd_valid_c,
   output logic                              rd_dirty_c,
   output logic [TAG_W-1:0]                  rd_tag_c,
   output logic [WORD_W*WORDS_PER_BLOCK-1:0] rd_data_c,
   input  logic                              word_we,
   input  logic [OFF_W-1:0]                  word_off,
   input  logic [WORD_W-1:0]                 word_data,
   input  logic                              line_we,
   input  logic [TAG_W-1:0]                  line_tag,
   input  logic [WORD_W*WORDS_PER_BLOCK-1:0] line_data,
   input  logic                              clr_dirty
);

   localparam int unsigned BLK_W = WORD_W * WORDS_PER_BLOCK;
   localparam int unsigned SEL_W = clog2w(BLK_W);

   logic [SETS-1:0]  valid;
   logic [SETS-1:0]  dirty;
   logic [TAG_W-1:0] tag_mem  [SETS];
   logic [BLK_W-1:0] data_mem [SETS];
   logic [SEL_W-1:0] wr_lsb;

   assign wr_lsb     = SEL_W'(word_lsb(32'(word_off), WORDS_PER_BLOCK, WORD_W));
   assign rd_valid_c = valid[idx];
   assign rd_dirty_c = dirty[idx];
   assign rd_tag_c   = tag_mem[idx];
   assign rd_data_c  = data_mem[idx];

   // Line fill wins over word write; a word write marks the line dirty.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid <= '0;
         dirty <= '0;
      end else if (line_we) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (word_we) begin
         dirty[idx] <= 1'b1;
      end else if (clr_dirty) begin
         dirty[idx] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_mem[idx]  <= line_tag;
         data_mem[idx] <= line_data;
      end else if (word_we) begin
         data_mem[idx][wr_lsb +: WORD_W] <= word_data;
      end
   end

endmodule

// File: rtl/dcache_sa.sv
// Set-associative write-back, write-allocate data cache with write-back/refill FSM and perf counters.
module dcache_sa
   import dcache_sa_pkg::*;
#(
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned WORD_W          = 16,
   parameter int unsigned WORDS_PER_BLOCK = 4,
   parameter int unsigned SETS            = 4,
   parameter int unsigned WAYS            = 2,
   parameter int unsigned CNT_W           = 16
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              req_valid,
   input  logic                              req_we,
   input  logic [ADDR_W-1:0]                 req_addr,
   input  logic [WORD_W-1:0]                 req_wdata,
   output logic                              resp_valid,
   output logic [WORD_W-1:0]                 resp_rdata,
   output logic                              mem_req,
   output logic                              mem_we,
   output logic [ADDR_W-1:0]                 mem_addr,
   output logic [WORD_W*WORDS_PER_BLOCK-1:0] mem_wdata,
   input  logic [WORD_W*WORDS_PER_BLOCK-1:0] mem_rdata,
   input  logic                              mem_ack,
   output logic [CNT_W-1:0]                  hit_cnt,
   output logic [CNT_W-1:0]                  access_cnt
);

   localparam int unsigned OFF_W = clog2w(WORDS_PER_BLOCK);
   localparam int unsigned IDX_W = clog2w(SETS);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int unsigned BLK_W = WORD_W * WORDS_PER_BLOCK;
   localparam int unsigned SEL_W = clog2w(BLK_W);

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [OFF_W-1:0] req_off;
   logic [SEL_W-1:0] rd_lsb;

   assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
   assign req_idx = req_addr[OFF_W +: IDX_W];
   assign req_off = req_addr[OFF_W-1:0];
   assign rd_lsb  = SEL_W'(word_lsb(32'(req_off), WORDS_PER_BLOCK, WORD_W));

   logic             way_valid     [WAYS];
   logic             way_dirty     [WAYS];
   logic [TAG_W-1:0] way_tag       [WAYS];
   logic [BLK_W-1:0] way_data      [WAYS];
   logic             way_word_we   [WAYS];
   logic             way_line_we   [WAYS];
   logic             way_clr_dirty [WAYS];

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      dcache_way #(
         .SETS(SETS), .IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W),
         .WORD_W(WORD_W), .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
      ) u_way (
         .clk       (clk),
         .reset_n   (reset_n),
         .idx       (req_idx),
         .rd_valid_c(way_valid[g]),
         .rd_dirty_c(way_dirty[g]),
         .rd_tag_c  (way_tag[g]),
         .rd_data_c (way_data[g]),
         .word_we   (way_word_we[g]),
         .word_off  (req_off),
         .word_data (req_wdata),
         .line_we   (way_line_we[g]),
         .line_tag  (req_tag),
         .line_data (mem_rdata),
         .clr_dirty (way_clr_dirty[g])
      );
   end

   state_t           state, state_nx;
   logic             retry, retry_nx;
   logic             vic_q, vic_nx;
   logic [SETS-1:0]  lru, lru_nx;
   logic             resp_valid_nx;
   logic [WORD_W-1:0] resp_rdata_nx;
   logic             mem_req_nx, mem_we_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [BLK_W-1:0] mem_wdata_nx;
   logic [CNT_W-1:0] hit_cnt_nx, access_cnt_nx;

   logic             accept;
   logic             hit, hit_way, victim, vic_found, vic_valid, vic_dirty;
   logic [TAG_W-1:0] vic_tag;
   logic [BLK_W-1:0] hit_line, vic_line;

   assign accept = req_valid && (state == IDLE) && !resp_valid;

   // Tag compare and victim choice: lowest invalid way, else the LRU way.
   always_comb begin
      hit       = 1'b0;
      hit_way   = 1'b0;
      hit_line  = '0;
      vic_found = 1'b0;
      victim    = (WAYS == 2) ? lru[req_idx] : 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (way_valid[w] && (way_tag[w] == req_tag)) begin
            hit      = 1'b1;
            hit_way  = 1'(w);
            hit_line = way_data[w];
         end
         if (!way_valid[w] && !vic_found) begin
            victim    = 1'(w);
            vic_found = 1'b1;
         end
      end
      vic_valid = 1'b0;
      vic_dirty = 1'b0;
      vic_tag   = '0;
      vic_line  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (1'(w) == victim) begin
            vic_valid = way_valid[w];
            vic_dirty = way_dirty[w];
            vic_tag   = way_tag[w];
            vic_line  = way_data[w];
         end
      end
   end

   always_comb begin
      state_nx      = state;
      retry_nx      = retry;
      vic_nx        = vic_q;
      lru_nx        = lru;
      resp_valid_nx = 1'b0;
      resp_rdata_nx = resp_rdata;
      mem_req_nx    = mem_req;
      mem_we_nx     = mem_we;
      mem_addr_nx   = mem_addr;
      mem_wdata_nx  = mem_wdata;
      hit_cnt_nx    = hit_cnt;
      access_cnt_nx = access_cnt;
      for (int w = 0; w < WAYS; w++) begin
         way_word_we[w]   = 1'b0;
         way_line_we[w]   = 1'b0;
         way_clr_dirty[w] = 1'b0;
      end
      if (resp_valid) retry_nx = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               if (!retry) begin
                  access_cnt_nx = access_cnt + CNT_W'(1);
                  if (hit) hit_cnt_nx = hit_cnt + CNT_W'(1);
               end
               if (hit) begin
                  resp_valid_nx = 1'b1;
                  if (req_we) begin
                     for (int w = 0; w < WAYS; w++)
                        way_word_we[w] = (1'(w) == hit_way);
                  end else begin
                     resp_rdata_nx = hit_line[rd_lsb +: WORD_W];
                  end
                  if (WAYS == 2) lru_nx[req_idx] = ~hit_way;
               end else begin
                  retry_nx   = 1'b1;
                  vic_nx     = victim;
                  mem_req_nx = 1'b1;
                  if (vic_valid && vic_dirty) begin
                     state_nx     = WB;
                     mem_we_nx    = 1'b1;
                     mem_addr_nx  = {vic_tag, req_idx, {OFF_W{1'b0}}};
                     mem_wdata_nx = vic_line;
                  end else begin
                     state_nx    = REFILL;
                     mem_we_nx   = 1'b0;
                     mem_addr_nx = {req_tag, req_idx, {OFF_W{1'b0}}};
                  end
               end
            end
         end
         WB: begin
            if (mem_ack) begin
               for (int w = 0; w < WAYS; w++)
                  way_clr_dirty[w] = (1'(w) == vic_q);
               state_nx    = REFILL;
               mem_we_nx   = 1'b0;
               mem_addr_nx = {req_tag, req_idx, {OFF_W{1'b0}}};
            end
         end
         REFILL: begin
            if (mem_ack) begin
               for (int w = 0; w < WAYS; w++)
                  way_line_we[w] = (1'(w) == vic_q);
               state_nx   = IDLE;
               mem_req_nx = 1'b0;
               mem_we_nx  = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         retry      <= 1'b0;
         vic_q      <= 1'b0;
         lru        <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         hit_cnt    <= '0;
         access_cnt <= '0;
      end else begin
         state      <= state_nx;
         retry      <= retry_nx;
         vic_q      <= vic_nx;
         lru        <= lru_nx;
         resp_valid <= resp_valid_nx;
         resp_rdata <= resp_rdata_nx;
         mem_req    <= mem_req_nx;
         mem_we     <= mem_we_nx;
         mem_addr   <= mem_addr_nx;
         mem_wdata  <= mem_wdata_nx;
         hit_cnt    <= hit_cnt_nx;
         access_cnt <= access_cnt_nx;
      end
   end

endmodule
